// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming encoder and its decoder/checker
// counterparts: FSM state encoding, codeword bit positions and the parity
// equations used by every block that touches the (16,11) code.
package hamming_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DATA_W = 11;
    localparam int CW_W   = 16;

    // Parity bit positions inside the 16-bit codeword
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;
    localparam int P8 = 8;

    // Returns {p8, p4, p2, p1, p0} for data bits d[11:1].
    // p0 is the overall parity over data and Hamming parity bits, which
    // gives the double-error detection on the decode side.
    function automatic logic [4:0] hamming_parity(input logic [11:1] d);
        logic p8;
        logic p4;
        logic p2;
        logic p1;
        logic p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        return {p8, p4, p2, p1, p0};
    endfunction

endpackage

// File: rtl/hamming_enc_comb.sv
// Purely combinational 11-bit -> 16-bit SECDED Hamming encoder.
// data[0] is d1, data[10] is d11.
module hamming_enc_comb
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   codeword
);

    logic [11:1] d;
    logic [4:0]  par;

    assign d   = data;
    assign par = hamming_parity(d);

    // Interleave data and parity so each parity bit sits at its power-of-two position
    always_comb begin
        codeword        = '0;
        codeword[15:9]  = d[11:5];
        codeword[P8]    = par[4];
        codeword[7:5]   = d[4:2];
        codeword[P4]    = par[3];
        codeword[3]     = d[1];
        codeword[P2]    = par[2];
        codeword[P1]    = par[1];
        codeword[P0]    = par[0];
    end

endmodule

// File: rtl/hamming_encoder_engine.sv
// Memory-to-memory SECDED encoder accelerator. Reads NUM_MSG 11-bit
// messages stored as byte pairs, encodes each and writes the 16-bit
// codeword back as a byte pair. Both source bytes are read before either
// destination byte is written, so in-place encoding works.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, outputs quiet
// RD_LO | mem_addr on message low byte, captured at end of cycle
// RD_HI | mem_addr on message high byte, codeword registered at end
// WR_LO | writing codeword low byte
// WR_HI | writing codeword high byte, then next message or DONE
// DONE  | done high until start launches another run
module hamming_encoder_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);
    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

    state_t            state;
    logic [IW-1:0]     msg_idx;
    logic [7:0]        lo_byte;
    logic [7:0]        cw_hi;
    logic [DATA_W-1:0] enc_data;
    logic [CW_W-1:0]   enc_cw;

    // Address wraps naturally at 2^AW
    function automatic logic [AW-1:0] pair_addr(input logic [AW-1:0] base,
                                                input logic [IW-1:0] idx,
                                                input logic          hi);
        return base + (AW'(idx) << 1) + AW'(hi);
    endfunction

    // High byte comes straight off the read port during RD_HI; bits [7:3] are dropped
    assign enc_data = {mem_rd_data[2:0], lo_byte};

    hamming_enc_comb u_enc (
        .data     (enc_data),
        .codeword (enc_cw)
    );

    // Sequencer: outputs are registered on entry to the state they belong to
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            msg_idx     <= '0;
            lo_byte     <= '0;
            cw_hi       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RD_LO;
                        msg_idx  <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        mem_addr <= pair_addr(SRC_A, '0, 1'b0);
                    end
                end
                RD_LO: begin
                    lo_byte  <= mem_rd_data;
                    state    <= RD_HI;
                    mem_addr <= pair_addr(SRC_A, msg_idx, 1'b1);
                end
                RD_HI: begin
                    cw_hi       <= enc_cw[15:8];
                    state       <= WR_LO;
                    mem_addr    <= pair_addr(DST_A, msg_idx, 1'b0);
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= enc_cw[7:0];
                end
                WR_LO: begin
                    state       <= WR_HI;
                    mem_addr    <= pair_addr(DST_A, msg_idx, 1'b1);
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= cw_hi;
                end
                WR_HI: begin
                    if (msg_idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        msg_idx  <= msg_idx + IW'(1);
                        state    <= RD_LO;
                        mem_addr <= pair_addr(SRC_A, msg_idx + IW'(1), 1'b0);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_engine.sv
// Directed and seeded-random checks for hamming_encoder_engine with a
// behavioural byte memory on its data port.
module tb_hamming_encoder_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];
    int         strobe_cnt = 0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] cw;
    } vec_t;

    vec_t        vecs [15];
    logic [15:0] rnd_cw [15];

    hamming_encoder_engine #(
        .NUM_MSG  (15),
        .SRC_BASE (0),
        .DST_BASE (30),
        .AW       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            strobe_cnt    <= strobe_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference encoder built from positional Hamming rules: data fills the
    // non-power-of-two positions, parity bits zero the position syndrome.
    function automatic logic [15:0] model_enc(input logic [10:0] d);
        logic [15:0] cw;
        logic [3:0]  syn;
        int          k;
        cw  = '0;
        syn = '0;
        k   = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[k];
                k++;
                if (cw[pos]) syn = syn ^ 4'(pos);
            end
        end
        cw[1] = syn[0];
        cw[2] = syn[1];
        cw[4] = syn[2];
        cw[8] = syn[3];
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    // Returns {status, syndrome}: status 00 clean, 01 single, 10 double
    function automatic logic [5:0] model_dec(input logic [15:0] cw);
        logic [3:0] syn;
        logic [1:0] st;
        syn = '0;
        for (int pos = 1; pos < 16; pos++)
            if (cw[pos]) syn = syn ^ 4'(pos);
        if (^cw)              st = 2'b01;
        else if (syn != 4'd0) st = 2'b10;
        else                  st = 2'b00;
        return {st, syn};
    endfunction

    task automatic fill_dst(input logic [7:0] val);
        for (int a = 30; a < 60; a++) mem[a] = val;
    endtask

    // Launch a run from IDLE/DONE and wait for done; edges counts the
    // start-sampling edge as 1. poke_busy re-asserts start mid-run.
    task automatic run_job(input string tag, input bit poke_busy);
        int edges;
        int base;
        base  = strobe_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_done_after_start"}, done, 0);
        while (!done && edges < 200) begin
            if (poke_busy) start = (edges >= 8 && edges < 20);
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        chk({tag, "_done_edges"}, edges, 61);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_strobes"}, strobe_cnt - base, 30);
    endtask

    initial begin
        logic [15:0] cw;
        logic [15:0] bad;
        int          edges;
        int          base;

        vecs[0]  = '{8'h00, 8'h00, 16'h0000};
        vecs[1]  = '{8'hFF, 8'h07, 16'hFFFF};
        vecs[2]  = '{8'h01, 8'h00, 16'h000F};
        vecs[3]  = '{8'h00, 8'h04, 16'h8117};
        vecs[4]  = '{8'h00, 8'hF8, 16'h0000};
        vecs[5]  = '{8'h02, 8'h00, 16'h0033};
        vecs[6]  = '{8'h10, 8'h00, 16'h0303};
        vecs[7]  = '{8'h55, 8'h05, 16'hAA5A};
        vecs[8]  = '{8'hAA, 8'h02, 16'h55A5};
        vecs[9]  = '{8'h80, 8'h00, 16'h1111};
        vecs[10] = '{8'hFF, 8'hFF, 16'hFFFF};
        vecs[11] = '{8'h00, 8'hFC, 16'h8117};
        vecs[12] = '{8'h03, 8'h00, 16'h003C};
        vecs[13] = '{8'h90, 8'h00, 16'h1212};
        vecs[14] = '{8'h01, 8'h04, 16'h8118};

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // Directed table, with start poked while busy
        for (int i = 0; i < 15; i++) begin
            mem[2*i]     = vecs[i].lo;
            mem[2*i + 1] = vecs[i].hi;
        end
        fill_dst(8'hEE);
        run_job("tbl", 1'b1);
        for (int i = 0; i < 15; i++)
            chk($sformatf("tbl_cw%0d", i), {mem[31 + 2*i], mem[30 + 2*i]}, vecs[i].cw);
        chk("tbl_src_untouched", {mem[7], mem[6]}, {vecs[3].hi, vecs[3].lo});

        // Re-run from DONE must reproduce the same destination bytes
        fill_dst(8'hEE);
        run_job("rerun", 1'b0);
        for (int i = 0; i < 15; i++)
            chk($sformatf("rerun_cw%0d", i), {mem[31 + 2*i], mem[30 + 2*i]}, vecs[i].cw);

        // Seeded random messages plus single/double error decode
        void'($urandom(9));
        for (int i = 0; i < 15; i++) begin
            mem[2*i]     = 8'($urandom_range(0, 255));
            mem[2*i + 1] = 8'($urandom_range(0, 255));
            rnd_cw[i]    = model_enc({mem[2*i + 1][2:0], mem[2*i]});
        end
        fill_dst(8'h00);
        run_job("rnd", 1'b0);
        for (int i = 0; i < 15; i++) begin
            cw = {mem[31 + 2*i], mem[30 + 2*i]};
            chk($sformatf("rnd_cw%0d", i), cw, rnd_cw[i]);
            chk($sformatf("rnd_clean%0d", i), model_dec(cw), 6'b00_0000);
            for (int b = 0; b < 16; b++) begin
                bad = cw;
                bad[b] = ~bad[b];
                chk($sformatf("rnd_single%0d_b%0d", i, b), model_dec(bad), {2'b01, 4'(b)});
                bad[(b + 1) % 16] = ~bad[(b + 1) % 16];
                chk($sformatf("rnd_double%0d_b%0d", i, b), model_dec(bad) >> 4, 2'b10);
            end
        end

        // Reset in the cycle after message 5's WR_HI
        for (int i = 0; i < 15; i++) begin
            mem[2*i]     = vecs[i].lo;
            mem[2*i + 1] = vecs[i].hi;
        end
        for (int a = 30; a < 60; a++) mem[a] = 8'(a) ^ 8'h5A;
        base  = strobe_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0;
        while (edges < 25) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("abort_busy_before", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", mem_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_strobes", strobe_cnt - base, 12);
        chk("abort_idle_done", done, 0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("abort_cw%0d", i), {mem[31 + 2*i], mem[30 + 2*i]}, vecs[i].cw);
        for (int a = 42; a < 60; a++)
            chk($sformatf("abort_keep%0d", a), mem[a], 8'(a) ^ 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_engine.md
Name: hamming_encoder_engine

Overview:
- Hardware SECDED Hamming encoder. It is the transmit-side counterpart of the existing program-2 decoder flow.
- On start, it walks NUM_MSG 11-bit messages stored as byte pairs in data memory and computes the four Hamming parity bits plus the overall parity bit.
- Each 16-bit codeword is written back to data memory.
- It sits beside the core on the data-memory port as a self-contained accelerator with a start/done handshake.

Parameters:
- NUM_MSG, 15, number of messages processed per run
- SRC_BASE, 0, byte address of the first message low byte
- DST_BASE, 30, byte address of the first codeword low byte
- AW, 8, data-memory byte-address width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  level; sampled only in IDLE
- done  output  1  high while in DONE state
- busy  output  1  high in any state other than IDLE/DONE
- mem_addr  output  AW  byte address to data memory
- mem_rd_data  input  8  combinational read data for mem_addr (same cycle)
- mem_wr_en  output  1  write strobe; memory writes mem_wr_data at mem_addr on the clock edge
- mem_wr_data  output  8  write byte

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, msg index=0, done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, holding registers cleared.
- Reset mid-run aborts immediately: no further writes; bytes already written stay.
- Message i layout:
  - low byte at SRC_BASE+2i carries d[8:1] (bit0=d1).
  - high byte at SRC_BASE+2i+1 carries d[11:9] in bits [2:0]; bits [7:3] are ignored.
- Parity equations:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1]^p8^p4^p2^p1
- Codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
  - Low byte goes to DST_BASE+2i, high byte to DST_BASE+2i+1.
- FSM:
  - IDLE: done=0; start==1 -> RD_LO, index=0.
  - RD_LO: mem_addr=SRC_BASE+2i; latch low byte -> RD_HI.
  - RD_HI: mem_addr=SRC_BASE+2i+1; latch high[2:0]; register the codeword -> WR_LO.
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, data=cw[7:0] -> WR_HI.
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, data=cw[15:8]. If i==NUM_MSG-1 -> DONE; else i++ and -> RD_LO.
  - DONE: done=1, busy=0. Stays until start==1, which goes to RD_LO, re-runs, and drops done the same edge.
- Timing:
  - Exactly 4 cycles per message. For NUM_MSG=15, done rises 61 clock edges after the edge that samples start in IDLE.
  - mem_wr_en is asserted only in WR_LO/WR_HI, exactly 2*NUM_MSG strobes per run.
- start is ignored while busy. start held high through DONE produces a back-to-back re-run (legal).
- Address arithmetic is modulo 2^AW. Source/destination overlap is not checked; ordering (read both bytes before writing) makes in-place encoding (SRC_BASE==DST_BASE) correct.

Decomposition:
- Package hamming_pkg:
  - state enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE)
  - codeword bit-position localparams (P0=0, P1=1, P2=2, P4=4, P8=8)
  - a shared parity function, so the decoder and checker use the same equations
- Sub-module hamming_enc_comb: purely combinational 11-bit -> 16-bit encoder. The FSM, counter and memory sequencing live in hamming_encoder_engine.

Test Plan:
- Message 0x000 (bytes 0x00,0x00) -> codeword 0x0000 (bytes 0x00,0x00); done after 61 edges.
- Message 0x7FF (bytes 0xFF,0x07) -> 0xFFFF. Message 0x001 -> 0x000F. Message 0x400 (bytes 0x00,0x04) -> 0x8117.
- Junk in high bits: bytes 0x00,0xF8 -> 0x0000 (bits [7:3] ignored).
- 15 random messages (seed 9): each written codeword matches the model. Flipping any single bit and running the decoder model yields syndrome == flipped position with MSBs 2'b01; flipping two bits flags the double error.
- Reset pulled low in the cycle after message 5's WR_HI: bytes 30..41 hold codewords, bytes 42..59 keep their preloaded values, done=0, mem_wr_en=0 the following cycle.
- start asserted during busy: no restart, total strobes=30. Second start from DONE: done drops next edge and rises again 61 edges later with identical memory contents.
